// File: rtl/bus_pkg.sv
// Shared constants and types for the two-master data bus arbiter:
// address windows, master indices and the arbitration state encoding.
package bus_pkg;

    // Default address windows (12-bit master address space)
    localparam logic [11:0] DATA_BASE = 12'h200;
    localparam logic [11:0] PERI_BASE = 12'h700;
    localparam int          PERI_AW   = 5;

    // Master indices
    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    // Arbitration state: which master held the bus in the previous cycle
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } arb_state_e;

    // One-hot grant vector for a master index
    function automatic logic [1:0] master_onehot(input logic idx);
        logic [1:0] oh;
        if (idx == M1) begin
            oh = 2'b10;
        end else begin
            oh = 2'b01;
        end
        return oh;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter with bounded lock. Grant is combinational
// from the requests and the registered owner/last/lock-count state.
module rr_arbiter2
    import bus_pkg::*;
#(
    parameter int MAX_LOCK = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [1:0] lock,
    output logic [1:0] gnt
);

    localparam int                CNT_W   = $clog2(MAX_LOCK + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_LOCK);
    localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};

    arb_state_e       state_q, state_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;

    logic owner_vld_s;
    logic owner_s;
    logic gidx_s;

    // Decode the previous-cycle owner from the state register
    always_comb begin
        owner_vld_s = (state_q != IDLE);
        if (state_q == OWN1) begin
            owner_s = M1;
        end else begin
            owner_s = M0;
        end
    end

    // Grant selection: single requester wins, locked owner keeps the bus
    // while under the lock bound, otherwise alternate away from last
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b00: gnt = 2'b00;
            2'b01: gnt = 2'b01;
            2'b10: gnt = 2'b10;
            2'b11: begin
                if (owner_vld_s && lock[owner_s] && (lock_cnt_q < CNT_MAX)) begin
                    gnt = master_onehot(owner_s);
                end else begin
                    gnt = master_onehot(~last_q);
                end
            end
            default: gnt = 2'b00;
        endcase
    end

    // Next owner, last pointer and consecutive-lock counter
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        lock_cnt_d = lock_cnt_q;
        gidx_s     = gnt[1];
        if (gnt == 2'b00) begin
            state_d    = IDLE;
            lock_cnt_d = CNT_ZERO;
        end else begin
            if (gidx_s == M1) begin
                state_d = OWN1;
            end else begin
                state_d = OWN0;
            end
            last_d = gidx_s;
            if (owner_vld_s && (gidx_s == owner_s)) begin
                // Same master again: count only while the other one waits
                if (req[~gidx_s] && (lock_cnt_q < CNT_MAX)) begin
                    lock_cnt_d = lock_cnt_q + CNT_W'(1);
                end else begin
                    lock_cnt_d = lock_cnt_q;
                end
            end else begin
                lock_cnt_d = CNT_ZERO;
            end
        end
    end

    // Arbitration state registers; after reset M0 wins the first tie
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            last_q     <= M1;
            lock_cnt_q <= CNT_ZERO;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end

endmodule

// File: rtl/data_bus_arbiter.sv
// Shares the data memory and peripheral windows between the core load/store
// port (M0) and a second master (M1). Address decode, slave muxing and the
// one-cycle registered read response live here; arbitration is in rr_arbiter2.
module data_bus_arbiter #(
    parameter int                INST_MEM_N = 9,
    parameter int                DATA_MEM_N = 8,
    parameter int                ADDR_W     = 12,
    parameter logic [ADDR_W-1:0] PERI_BASE  = 12'h700,
    parameter int                MAX_LOCK   = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [1:0]                 m_req,
    input  logic [1:0]                 m_lock,
    input  logic [1:0]                 m_we,
    input  logic [ADDR_W-1:0]          m0_addr,
    input  logic [ADDR_W-1:0]          m1_addr,
    input  logic [31:0]                m0_wdata,
    input  logic [31:0]                m1_wdata,
    output logic [1:0]                 m_gnt,
    output logic [1:0]                 m_rvalid,
    output logic                       m_rerr,
    output logic [31:0]                m_rdata,
    output logic [DATA_MEM_N-1:0]      mem_addr,
    output logic [31:0]                mem_wd,
    output logic [31:0]                peri_wd,
    output logic                       mem_we,
    output logic                       peri_we,
    input  logic [31:0]                mem_rd,
    input  logic [31:0]                peri_rd,
    output logic [bus_pkg::PERI_AW-1:0] peri_addr
);

    // Window bounds widened to 32 bits so the upper bound never overflows
    localparam logic [31:0] MEM_LO_C  = 32'd1 << INST_MEM_N;
    localparam logic [31:0] MEM_HI_C  = MEM_LO_C + (32'd1 << DATA_MEM_N);
    localparam logic [31:0] PERI_LO_C = 32'(PERI_BASE);

    logic [1:0]        gnt_s;
    logic              any_gnt_s;
    logic [ADDR_W-1:0] addr_s;
    logic [31:0]       addr_ext_s;
    logic              we_s;
    logic [31:0]       wdata_s;
    logic              hit_mem_s;
    logic              hit_peri_s;
    logic              rd_s;

    logic [1:0]  rvalid_d, rvalid_q;
    logic        rerr_d, rerr_q;
    logic [31:0] rdata_d, rdata_q;

    rr_arbiter2 #(
        .MAX_LOCK (MAX_LOCK)
    ) u_arb (
        .clk  (clk),
        .rst  (rst),
        .req  (m_req),
        .lock (m_lock),
        .gnt  (gnt_s)
    );

    assign m_gnt = gnt_s;

    // Select the granted master's command; with no grant M0 drives the slaves
    always_comb begin
        any_gnt_s = |gnt_s;
        if (gnt_s[1]) begin
            addr_s  = m1_addr;
            we_s    = m_we[1];
            wdata_s = m1_wdata;
        end else begin
            addr_s  = m0_addr;
            we_s    = m_we[0];
            wdata_s = m0_wdata;
        end
    end

    // Address decode and slave-side addresses, data and write strobes
    always_comb begin
        addr_ext_s = 32'(addr_s);
        hit_mem_s  = (addr_ext_s >= MEM_LO_C) && (addr_ext_s < MEM_HI_C);
        hit_peri_s = (addr_ext_s >= PERI_LO_C);
        mem_addr   = DATA_MEM_N'(addr_ext_s - MEM_LO_C);
        peri_addr  = bus_pkg::PERI_AW'(addr_ext_s - PERI_LO_C);
        mem_wd     = wdata_s;
        peri_wd    = wdata_s;
        mem_we     = any_gnt_s & we_s & hit_mem_s;
        peri_we    = any_gnt_s & we_s & hit_peri_s;
        rd_s       = any_gnt_s & ~we_s;
    end

    // Read response capture: data from the hit window, zero plus error on a miss
    always_comb begin
        rvalid_d = 2'b00;
        rerr_d   = 1'b0;
        rdata_d  = rdata_q;
        if (rd_s) begin
            rvalid_d = gnt_s;
            if (hit_mem_s) begin
                rdata_d = mem_rd;
            end else if (hit_peri_s) begin
                rdata_d = peri_rd;
            end else begin
                rdata_d = 32'h0000_0000;
                rerr_d  = 1'b1;
            end
        end else begin
            rvalid_d = 2'b00;
            rerr_d   = 1'b0;
        end
    end

    // Read response registers; reset drops any response in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid_q <= 2'b00;
            rerr_q   <= 1'b0;
            rdata_q  <= 32'h0000_0000;
        end else begin
            rvalid_q <= rvalid_d;
            rerr_q   <= rerr_d;
            rdata_q  <= rdata_d;
        end
    end

    assign m_rvalid = rvalid_q;
    assign m_rerr   = rerr_q;
    assign m_rdata  = rdata_q;

endmodule
